// File: rtl/platform_switch_poll_ctrl.sv
// Polls a switch PIO on a fixed period, debounces the sampled bits and exposes
// STATE/EDGE/MASK/CTRL registers. Define SWITCH_POLL_IRQ_EN to build MASK and irq.
module platform_switch_poll_ctrl #(
  parameter int SW_W       = 1,
  parameter int POLL_DIV   = 50000,
  parameter int DEBOUNCE_N = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [1:0]  pio_address,
  input  logic [31:0] pio_readdata,
  input  logic [1:0]  s_address,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic        irq
);

  localparam int            TW        = $clog2(POLL_DIV);
  localparam logic [TW-1:0] TIMER_MAX = TW'(POLL_DIV - 1);
  localparam logic [3:0]    DEB_MAX   = 4'(DEBOUNCE_N);

  typedef enum logic [1:0] {IDLE, ADDR, WAIT, CAPT} state_t;

  state_t          r_state, w_state_nxt;
  logic [TW-1:0]   r_timer, w_timer_nxt;
  logic [SW_W-1:0] r_stable, r_cand, r_edge;
  logic [SW_W-1:0] w_sample, w_cand_nxt, w_set, w_clr, w_mask;
  logic [3:0]      r_cnt, w_cnt_nxt;
  logic            r_en, r_force, w_start, w_accept;
  logic            w_wr_edge, w_wr_mask, w_wr_ctrl;
  logic [31:0]     r_rdata, w_rd_mux;
  logic            w_unused;

  // Upper PIO/CSR data bits are intentionally ignored.
  assign w_unused = ^{pio_readdata, s_writedata, w_wr_mask};

  assign pio_address = (r_state == ADDR || r_state == WAIT) ? 2'b00 : 2'b11;
  assign s_readdata  = r_rdata;

  assign w_wr_edge = s_write && (s_address == 2'd1);
  assign w_wr_mask = s_write && (s_address == 2'd2);
  assign w_wr_ctrl = s_write && (s_address == 2'd3);
  assign w_clr     = w_wr_edge ? s_writedata[SW_W-1:0] : '0;

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_start     = 1'b0;
    case (r_state)
      IDLE: begin
        w_start = r_force || (r_en && r_timer == TIMER_MAX);
        if (w_start) begin
          w_state_nxt = ADDR;
          w_timer_nxt = '0;
        end else if (!r_en) begin
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      ADDR:    w_state_nxt = WAIT;
      WAIT:    w_state_nxt = CAPT;
      CAPT:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Acceptance looks at the post-update count so a change can be taken in the same CAPT.
  always_comb begin
    w_sample   = pio_readdata[SW_W-1:0];
    w_cand_nxt = r_cand;
    w_cnt_nxt  = r_cnt;
    w_set      = '0;
    if (r_state == CAPT) begin
      if (w_sample == r_cand) begin
        if (r_cnt < DEB_MAX) w_cnt_nxt = r_cnt + 1'b1;
      end else begin
        w_cand_nxt = w_sample;
        w_cnt_nxt  = 4'd1;
      end
      if (w_cnt_nxt == DEB_MAX && w_cand_nxt != r_stable) w_set = w_cand_nxt ^ r_stable;
    end
  end

  assign w_accept = |w_set;

  always_comb begin
    w_rd_mux = '0;
    case (s_address)
      2'd0:    w_rd_mux[SW_W-1:0] = r_stable;
      2'd1:    w_rd_mux[SW_W-1:0] = r_edge;
      2'd2:    w_rd_mux[SW_W-1:0] = w_mask;
      default: w_rd_mux[0]        = r_en;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_timer  <= '0;
      r_stable <= '0;
      r_cand   <= '0;
      r_cnt    <= '0;
      r_edge   <= '0;
      r_en     <= 1'b1;
      r_force  <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_cand  <= w_cand_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) r_stable <= w_cand_nxt;
      r_edge <= (r_edge & ~w_clr) | w_set;
      if (w_wr_ctrl) r_en <= s_writedata[0];
      // A force request arriving mid-poll stays pending until the FSM is back in IDLE.
      if (w_wr_ctrl && s_writedata[1]) r_force <= 1'b1;
      else if (r_state == IDLE)        r_force <= 1'b0;
      if (s_read) r_rdata <= w_rd_mux;
    end
  end

`ifdef SWITCH_POLL_IRQ_EN
  logic [SW_W-1:0] r_mask;
  logic            r_irq;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask <= '0;
      r_irq  <= 1'b0;
    end else begin
      if (w_wr_mask) r_mask <= s_writedata[SW_W-1:0];
      r_irq <= |(r_edge & r_mask);
    end
  end

  assign w_mask = r_mask;
  assign irq    = r_irq;
`else
  assign w_mask = '0;
  assign irq    = 1'b0;
`endif

endmodule

// File: tb/tb_platform_switch_poll_ctrl.sv
// Directed + randomized bench for platform_switch_poll_ctrl, checked cycle by cycle
// against a time-based poll schedule and debounce model.
module tb_platform_switch_poll_ctrl;

  localparam int POLL_DIV = 8;
  localparam int DEB_N    = 3;
`ifdef SWITCH_POLL_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  pio_address;
  logic [31:0] pio_readdata;
  logic [1:0]  s_address;
  logic        s_read, s_write;
  logic [31:0] s_writedata;
  logic [31:0] s_readdata;
  logic        irq;
  logic        sw;

  int n_cmp = 0;
  int n_err = 0;

  platform_switch_poll_ctrl #(.SW_W(1), .POLL_DIV(POLL_DIV), .DEBOUNCE_N(DEB_N)) dut (
    .clk(clk), .reset(reset), .pio_address(pio_address), .pio_readdata(pio_readdata),
    .s_address(s_address), .s_read(s_read), .s_write(s_write), .s_writedata(s_writedata),
    .s_readdata(s_readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  // Registered switch PIO: address 0 returns the switch, anything else returns its inverse.
  always @(posedge clk) begin
    if (pio_address == 2'b00) pio_readdata <= ($urandom & 32'hFFFF_FFFE) | {31'b0, sw};
    else                      pio_readdata <= ($urandom & 32'hFFFF_FFFE) | {31'b0, ~sw};
  end

  // Reference model: polls are tracked by the cycle number their ADDR phase starts.
  int          cyc = 0;
  int          m_poll_t = -1;
  int          m_idle_since = 1;
  int          m_cnt = 0;
  logic        m_en = 1'b1, m_force = 1'b0, m_samp = 1'b0;
  logic        m_cand = 1'b0, m_stable = 1'b0, m_edge = 1'b0, m_mask = 1'b0, m_irq = 1'b0;
  logic [31:0] m_rdata = '0;
  bit          m_capt = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    int          ph, n_cnt, n_poll_t, n_idle;
    logic        n_en, n_force, n_samp, n_cand, n_stable, n_edge, n_mask, n_irq, set, clr;
    logic [31:0] n_rdata;
    bit          n_capt;
    ph = (m_poll_t >= 0) ? cyc - m_poll_t : -1;
    n_cnt = m_cnt; n_poll_t = m_poll_t; n_idle = m_idle_since;
    n_en = m_en; n_force = m_force; n_samp = m_samp; n_cand = m_cand;
    n_stable = m_stable; n_mask = m_mask; n_rdata = m_rdata;
    set = 1'b0; clr = 1'b0; n_capt = 1'b0;
    if (s_read) begin
      case (s_address)
        2'd0:    n_rdata = {31'b0, m_stable};
        2'd1:    n_rdata = {31'b0, m_edge};
        2'd2:    n_rdata = {31'b0, m_mask};
        default: n_rdata = {31'b0, m_en};
      endcase
    end
    n_irq = IRQ_ON & m_edge & m_mask;
    if (ph == 1) n_samp = sw;
    if (ph == 2) begin
      if (m_samp == m_cand) n_cnt = (m_cnt < DEB_N) ? m_cnt + 1 : DEB_N;
      else begin n_cand = m_samp; n_cnt = 1; end
      if (n_cnt == DEB_N && n_cand != m_stable) begin set = 1'b1; n_stable = n_cand; end
      n_poll_t = -1; n_idle = cyc + 1; n_capt = 1'b1;
    end
    if (ph < 0) begin
      if (m_force) begin n_poll_t = cyc + 1; n_force = 1'b0; end
      else if (m_en && (cyc - m_idle_since) == POLL_DIV - 1) n_poll_t = cyc + 1;
      if (!m_en) n_idle = cyc + 1;
    end
    if (s_write) begin
      case (s_address)
        2'd1: clr = s_writedata[0];
        2'd2: if (IRQ_ON) n_mask = s_writedata[0];
        2'd3: begin n_en = s_writedata[0]; if (s_writedata[1]) n_force = 1'b1; end
        default: ;
      endcase
    end
    n_edge = (m_edge & ~clr) | set;
    if (reset) begin
      n_poll_t = -1; n_idle = cyc + 1; n_cnt = 0; n_en = 1'b1; n_force = 1'b0;
      n_cand = 1'b0; n_stable = 1'b0; n_edge = 1'b0; n_mask = 1'b0; n_irq = 1'b0;
      n_rdata = '0; n_capt = 1'b0;
    end
    @(posedge clk); #1;
    m_cnt = n_cnt; m_poll_t = n_poll_t; m_idle_since = n_idle; m_en = n_en; m_force = n_force;
    m_samp = n_samp; m_cand = n_cand; m_stable = n_stable; m_edge = n_edge; m_mask = n_mask;
    m_irq = n_irq; m_rdata = n_rdata; m_capt = n_capt;
    cyc++;
    chk("pio_address", {30'b0, pio_address},
        (m_poll_t >= 0 && cyc - m_poll_t <= 1) ? 32'd0 : 32'd3);
    chk("irq", {31'b0, irq}, {31'b0, m_irq});
    chk("s_readdata", s_readdata, m_rdata);
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    s_address = a; s_writedata = d; s_write = 1'b1;
    tick();
    s_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
    s_address = a; s_read = 1'b1;
    tick();
    s_read = 1'b0;
    d = s_readdata;
  endtask

  task automatic wait_capt(input string tag);
    int n = 0;
    do begin tick(); n++; end while (!m_capt && n < 40);
    n_cmp++;
    assert (m_capt) else begin
      n_err++;
      $error("FAIL %s: no poll capture within %0d cycles, observed 0 expected 1", tag, n);
    end
  endtask

  task automatic wait_capt_phase(input string tag);
    int n = 0;
    while (!(m_poll_t >= 0 && cyc - m_poll_t == 2) && n < 40) begin tick(); n++; end
    n_cmp++;
    assert (m_poll_t >= 0 && cyc - m_poll_t == 2) else begin
      n_err++;
      $error("FAIL %s: no CAPT cycle within %0d cycles, observed 0 expected 1", tag, n);
    end
  endtask

  initial begin
    logic [31:0] d;
    int          naddr;
    int          a;
    reset = 1'b1; s_address = '0; s_read = 1'b0; s_write = 1'b0; s_writedata = '0; sw = 1'b1;
    tick(); tick();
    reset = 1'b0;
    csr_rd(2'd0, d); chk("rst_state", d, 32'd0);
    csr_rd(2'd3, d); chk("rst_ctrl_enable", d, 32'd1);

    // V1: switch held at 1 is accepted on the third capture
    wait_capt("v1_c1"); wait_capt("v1_c2");
    csr_rd(2'd0, d); chk("v1_state_early", d, 32'd0);
    wait_capt("v1_c3");
    csr_rd(2'd0, d); chk("v1_state", d, 32'd1);
    csr_rd(2'd1, d); chk("v1_edge", d, 32'd1);
    chk("v1_irq_masked", {31'b0, irq}, 32'd0);

    // V2: masked edge raises irq, W1C drops it
    csr_wr(2'd1, 32'd1);
    csr_wr(2'd2, 32'd1);
    sw = 1'b0;
    for (int i = 0; i < 6 && m_stable != 1'b0; i++) wait_capt("v2_poll");
    chk("v2_irq_before", {31'b0, irq}, 32'd0);
    tick();
    chk("v2_irq_set", {31'b0, irq}, {31'b0, IRQ_ON});
    csr_wr(2'd1, 32'd1);
    tick();
    chk("v2_irq_clr", {31'b0, irq}, 32'd0);

    // V3: bounce 1,0,1,1,1 yields one transition after the final 1
    wait_capt("v3_sync");
    csr_rd(2'd1, d); chk("v3_edge_pre", d, 32'd0);
    sw = 1'b1; wait_capt("v3_1");
    sw = 1'b0; wait_capt("v3_2");
    sw = 1'b1; wait_capt("v3_3");
    wait_capt("v3_4");
    csr_rd(2'd0, d); chk("v3_state_early", d, 32'd0);
    csr_rd(2'd1, d); chk("v3_edge_early", d, 32'd0);
    wait_capt("v3_5");
    csr_rd(2'd0, d); chk("v3_state", d, 32'd1);
    csr_rd(2'd1, d); chk("v3_edge", d, 32'd1);

    // V4: W1C coinciding with a new edge keeps EDGE set
    sw = 1'b0;
    wait_capt("v4_1"); wait_capt("v4_2");
    wait_capt_phase("v4_capt");
    csr_wr(2'd1, 32'd1);
    csr_rd(2'd1, d); chk("v4_edge_set_wins", d, 32'd1);
    csr_rd(2'd0, d); chk("v4_state", d, 32'd0);

    // V5: disabled timer, a single forced poll
    csr_wr(2'd3, 32'd0);
    repeat (25) tick();
    csr_wr(2'd3, 32'd2);
    naddr = 0;
    for (int i = 0; i < 30; i++) begin tick(); if (pio_address == 2'b00) naddr++; end
    chk("v5_force_addr_cycles", naddr, 32'd2);
    csr_rd(2'd3, d); chk("v5_ctrl_read", d, 32'd0);

    // V6: MASK readback depends on the build
    csr_wr(2'd2, 32'd1);
    csr_rd(2'd2, d); chk("v6_mask_read", d, {31'b0, IRQ_ON});
    csr_wr(2'd3, 32'd1);

    // Randomized traffic against the model, with occasional mid-poll resets
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(59) == 0) sw = ~sw;
      if ($urandom_range(299) == 0) begin
        reset = 1'b1; tick(); reset = 1'b0;
      end else if ($urandom_range(7) == 0) begin
        a = $urandom_range(3);
        d = $urandom;
        if (a == 3 && $urandom_range(3) != 0) d[0] = 1'b1;
        s_address = 2'(a); s_writedata = d;
        s_read = 1'($urandom_range(1)); s_write = 1'($urandom_range(1));
        tick();
        s_read = 1'b0; s_write = 1'b0;
      end else begin
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
